dogx_digital_converter_v2: RTL and testbench
============================================

// Module: dogx_digital_converter_v2
// PURPOSE
//  Back end of the DOGX dual-range VCO ADC. Samples four free-running 9-bit
//  oscillator phase counters: HSNR (high-gain) and HDR (1/4 gain), each with p/n
//  halves. Each cycle it forms differential phase increments and selects/blends the
//  two ranges with a hysteretic alpha decision. Optional DC removal is applied before
//  the signed 11-bit output. Sits between the graycount/extender counters and the decimator.
// PARAMETERS
//  HDR_SHIFT   2    log2 of HSNR/HDR gain ratio; HDR path is scaled by 2**HDR_SHIFT
//  DC_SHIFT    10   DC-filter leak coefficient, 2**-DC_SHIFT
//  FADE_STEPS  4    progressive-alpha crossfade length in cycles (power of 2)
// PORTS
//  CLK_24M                input   1  system clock, 24.576 MHz nominal
//  reset                  input   1  asynchronous, active-low reset
//  counter_HSNR_n         input   9  HSNR n-side phase counter, wraps mod 512
//  counter_HSNR_p         input   9  HSNR p-side phase counter
//  counter_HDR_n          input   9  HDR n-side phase counter
//  counter_HDR_p          input   9  HDR p-side phase counter
//  alpha_th_high          input   9  |HDR diff| above this -> request HDR (alpha=1)
//  alpha_th_low           input   9  |HDR diff| below this arms return to HSNR
//  alpha_timeout_mask     input   5  timeout expires when (timeout_cnt & mask)!=0
//  use_progressive_alpha  input   1  1: crossfade between ranges; 0: hard switch
//  use_dc_filter          input   1  1: subtract tracked DC before output
//  alpha_out              output  1  alpha decision of this instance
//  alpha_in               input   1  alpha actually applied (external tie/shared)
//  converter_output       output 11  signed two's-complement sample, one per cycle
// BEHAVIOUR
//  - Reset (reset==0, async): all regs 0; alpha_out=0, converter_output=0,
//    prev counters=0, first_flag=1, fade weight=0, DC accumulator=0.
//  - Cycle after reset release: load prev counters only; output stays 0; clear first_flag.
//  - Increments: d_x = (counter_x - prev_x) mod 512, unsigned 9 bit; prev_x <= counter_x.
//  - Differential: hsnr = d_HSNR_p - d_HSNR_n, hdr = d_HDR_p - d_HDR_n, signed 10 bit.
//  - Alpha FSM (updates every cycle from current |hdr|):
//    LOW (alpha_out=0): |hdr| > alpha_th_high -> HIGH, timeout_cnt=0.
//    HIGH (alpha_out=1): |hdr| < alpha_th_low -> timeout_cnt++, else timeout_cnt=0;
//    (timeout_cnt & mask)!=0 -> LOW. mask=0 -> never times out.
//    |hdr| > th_high while in HIGH resets timeout_cnt. Counter 5 bit, saturates at 31.
//  - Selection uses alpha_in, not alpha_out:
//    hard mode: sel = alpha_in ? (hdr <<< HDR_SHIFT) : hsnr.
//    progressive: weight w steps +1/-1 per cycle toward FADE_STEPS/0 per alpha_in;
//    sel = (w*(hdr<<<HDR_SHIFT) + (FADE_STEPS-w)*hsnr) >>> log2(FADE_STEPS).
//    w is held at 0 when progressive is off.
//  - DC filter: acc (sel width + DC_SHIFT frac bits) += sel - (acc>>>DC_SHIFT).
//    Output = sel - (acc>>>DC_SHIFT). Filter off: output = sel, acc held at 0.
//  - Output saturates to [-1024, +1023]; registered, 1-cycle latency from counter sample.
//  - Counter wrap (e.g. 500 -> 10) gives d=22; no special handling needed.
//  - Config inputs are sampled every cycle; changes take effect the next cycle.
// TESTING
//  - Reset: hold reset=0 with counters running -> output=0, alpha_out=0.
//    After release, first output sample is also 0.
//  - Equal p/n rates (all counters +262/cycle, wrapping) -> hsnr=hdr=0, output 0, alpha 0.
//  - HSNR p +270, n +254; HDR p +264, n +260, alpha_in=0 -> output=16.
//    Same with alpha_in tied to alpha_out, th_high=3 -> alpha 1, output=16 (4*4).
//  - Hysteresis: th_high=10, th_low=7, mask=00100; |hdr|=12 -> alpha_out=1 next cycle.
//    Then |hdr|=5 -> alpha_out back to 0 after exactly 4 cycles.
//  - Progressive on, alpha_in 0->1 with hsnr=16, hdr=8 -> outputs 16,20,24,28,32.
//  - DC filter on, constant sel=100 -> output decays toward 0; overflow: hdr=300, alpha 1
//    -> output=1023.

Source files
------------

// File: rtl/dogx_digital_converter_v2_if.sv
// Bus between the DOGX counter front end and the digital converter.
//   counter_*              9-bit free-running phase counters (HSNR/HDR, p/n halves)
//   alpha_th_high/low      hysteresis thresholds on |HDR differential|
//   alpha_timeout_mask     timeout expires when (timeout_cnt & mask) != 0
//   use_progressive_alpha  crossfade between ranges instead of a hard switch
//   use_dc_filter          subtract tracked DC before the output
//   alpha_in               alpha actually applied to range selection
//   alpha_out              alpha decision of the converter
//   converter_output       signed 11-bit sample, one per clock
interface dogx_digital_converter_v2_if;
    logic [8:0]         counter_HSNR_n;
    logic [8:0]         counter_HSNR_p;
    logic [8:0]         counter_HDR_n;
    logic [8:0]         counter_HDR_p;
    logic [8:0]         alpha_th_high;
    logic [8:0]         alpha_th_low;
    logic [4:0]         alpha_timeout_mask;
    logic               use_progressive_alpha;
    logic               use_dc_filter;
    logic               alpha_in;
    logic               alpha_out;
    logic signed [10:0] converter_output;

    modport master (
        output counter_HSNR_n, counter_HSNR_p, counter_HDR_n, counter_HDR_p,
        output alpha_th_high, alpha_th_low, alpha_timeout_mask,
        output use_progressive_alpha, use_dc_filter, alpha_in,
        input  alpha_out, converter_output
    );

    modport slave (
        input  counter_HSNR_n, counter_HSNR_p, counter_HDR_n, counter_HDR_p,
        input  alpha_th_high, alpha_th_low, alpha_timeout_mask,
        input  use_progressive_alpha, use_dc_filter, alpha_in,
        output alpha_out, converter_output
    );
endinterface

// File: rtl/dogx_digital_converter_v2.sv
// DOGX dual-range VCO ADC back end. Differentiates four 9-bit phase counters,
// picks/blends the HSNR and HDR ranges with a hysteretic alpha decision, optionally
// removes DC, and produces a saturated signed 11-bit sample every clock.
// Ports:
//   CLK_24M  system clock
//   reset    asynchronous active-low reset
//   io_bus   converter bus (slave side), see dogx_digital_converter_v2_if
module dogx_digital_converter_v2 #(
    parameter int unsigned HDR_SHIFT  = 2,
    parameter int unsigned DC_SHIFT   = 10,
    parameter int unsigned FADE_STEPS = 4
) (
    input  logic                         CLK_24M,
    input  logic                         reset,
    dogx_digital_converter_v2_if.slave   io_bus
);

    localparam int unsigned FadeLog2 = $clog2(FADE_STEPS);
    localparam int unsigned WgtW     = FadeLog2 + 1;
    localparam int unsigned SelW     = 10 + HDR_SHIFT;
    localparam int unsigned BlendW   = SelW + FadeLog2 + 2;
    localparam int unsigned AccW     = SelW + DC_SHIFT + 1;
    localparam int unsigned PreW     = SelW + 1;

    localparam logic signed [PreW-1:0] SatHi = PreW'(1023);
    localparam logic signed [PreW-1:0] SatLo = PreW'(-1024);

    typedef enum logic {StLow, StHigh} alpha_state_e;

    alpha_state_e            r_state, w_state_next;
    logic [4:0]              r_timeout_cnt, w_timeout_cnt_next;
    logic [8:0]              r_prev_hsnr_p, r_prev_hsnr_n, r_prev_hdr_p, r_prev_hdr_n;
    logic                    r_first;
    logic [WgtW-1:0]         r_weight, w_weight_next;
    logic signed [AccW-1:0]  r_acc, w_acc_next;
    logic signed [10:0]      r_out, w_out_next;

    logic [8:0]              w_d_hsnr_p, w_d_hsnr_n, w_d_hdr_p, w_d_hdr_n;
    logic signed [9:0]       w_hsnr, w_hdr;
    logic [9:0]              w_hdr_abs;
    logic signed [SelW-1:0]  w_hsnr_ext, w_hdr_scaled, w_sel_prog, w_sel, w_dc;
    logic [WgtW-1:0]         w_weight_inv;
    logic signed [BlendW-1:0] w_blend;
    logic signed [PreW-1:0]  w_pre;

    // Phase increments: modular subtraction absorbs counter wrap.
    assign w_d_hsnr_p = io_bus.counter_HSNR_p - r_prev_hsnr_p;
    assign w_d_hsnr_n = io_bus.counter_HSNR_n - r_prev_hsnr_n;
    assign w_d_hdr_p  = io_bus.counter_HDR_p - r_prev_hdr_p;
    assign w_d_hdr_n  = io_bus.counter_HDR_n - r_prev_hdr_n;

    assign w_hsnr = $signed({1'b0, w_d_hsnr_p}) - $signed({1'b0, w_d_hsnr_n});
    assign w_hdr  = $signed({1'b0, w_d_hdr_p}) - $signed({1'b0, w_d_hdr_n});

    // Differential never reaches -512, so negation cannot overflow.
    assign w_hdr_abs = w_hdr[9] ? $unsigned(-w_hdr) : $unsigned(w_hdr);

    assign w_hsnr_ext   = SelW'(w_hsnr);
    assign w_hdr_scaled = SelW'(w_hdr) <<< HDR_SHIFT;

    // Crossfade: weighted average of the gain-matched ranges.
    assign w_weight_inv = WgtW'(FADE_STEPS) - r_weight;
    assign w_blend = BlendW'($signed({1'b0, r_weight})) * BlendW'(w_hdr_scaled)
                   + BlendW'($signed({1'b0, w_weight_inv})) * BlendW'(w_hsnr_ext);
    assign w_sel_prog = SelW'(w_blend >>> FadeLog2);

    always_comb begin
        w_sel = w_hsnr_ext;
        if (io_bus.use_progressive_alpha) begin
            w_sel = w_sel_prog;
        end else if (io_bus.alpha_in) begin
            w_sel = w_hdr_scaled;
        end
    end

    // DC tracker: leaky integrator of the corrected output.
    assign w_dc = SelW'(r_acc >>> DC_SHIFT);

    always_comb begin
        w_pre      = PreW'(w_sel);
        w_acc_next = '0;
        if (io_bus.use_dc_filter) begin
            w_pre      = PreW'(w_sel) - PreW'(w_dc);
            w_acc_next = r_acc + AccW'(w_pre);
        end
    end

    always_comb begin
        if (w_pre > SatHi) begin
            w_out_next = 11'(SatHi);
        end else if (w_pre < SatLo) begin
            w_out_next = 11'(SatLo);
        end else begin
            w_out_next = 11'(w_pre);
        end
    end

    always_comb begin
        w_weight_next = r_weight;
        if (!io_bus.use_progressive_alpha) begin
            w_weight_next = '0;
        end else if (io_bus.alpha_in && (r_weight != WgtW'(FADE_STEPS))) begin
            w_weight_next = r_weight + WgtW'(1);
        end else if (!io_bus.alpha_in && (r_weight != '0)) begin
            w_weight_next = r_weight - WgtW'(1);
        end
    end

    // Alpha hysteresis FSM.
    always_comb begin
        w_state_next       = r_state;
        w_timeout_cnt_next = r_timeout_cnt;
        unique case (r_state)
            StLow: begin
                if (w_hdr_abs > {1'b0, io_bus.alpha_th_high}) begin
                    w_state_next       = StHigh;
                    w_timeout_cnt_next = '0;
                end
            end
            StHigh: begin
                if (w_hdr_abs > {1'b0, io_bus.alpha_th_high}) begin
                    w_timeout_cnt_next = '0;
                end else if (w_hdr_abs < {1'b0, io_bus.alpha_th_low}) begin
                    w_timeout_cnt_next = (r_timeout_cnt == 5'd31) ? 5'd31
                                                                   : r_timeout_cnt + 5'd1;
                end else begin
                    w_timeout_cnt_next = '0;
                end
                // Checked on the updated count so the exit lands on the masked bit.
                if ((w_timeout_cnt_next & io_bus.alpha_timeout_mask) != 5'd0) begin
                    w_state_next       = StLow;
                    w_timeout_cnt_next = '0;
                end
            end
            default: begin
                w_state_next       = StLow;
                w_timeout_cnt_next = '0;
            end
        endcase
    end

    always_ff @(posedge CLK_24M or negedge reset) begin
        if (!reset) begin
            r_state       <= StLow;
            r_timeout_cnt <= '0;
            r_prev_hsnr_p <= '0;
            r_prev_hsnr_n <= '0;
            r_prev_hdr_p  <= '0;
            r_prev_hdr_n  <= '0;
            r_first       <= 1'b1;
            r_weight      <= '0;
            r_acc         <= '0;
            r_out         <= '0;
        end else begin
            r_prev_hsnr_p <= io_bus.counter_HSNR_p;
            r_prev_hsnr_n <= io_bus.counter_HSNR_n;
            r_prev_hdr_p  <= io_bus.counter_HDR_p;
            r_prev_hdr_n  <= io_bus.counter_HDR_n;
            r_first       <= 1'b0;
            // First cycle only seeds the previous-counter registers.
            if (!r_first) begin
                r_state       <= w_state_next;
                r_timeout_cnt <= w_timeout_cnt_next;
                r_weight      <= w_weight_next;
                r_acc         <= w_acc_next;
                r_out         <= w_out_next;
            end
        end
    end

    assign io_bus.alpha_out        = (r_state == StHigh);
    assign io_bus.converter_output = r_out;

endmodule

// File: tb/tb_dogx_digital_converter_v2.sv
// Directed self-checking bench for dogx_digital_converter_v2.
module tb_dogx_digital_converter_v2;

    logic clk;
    logic rst_n;
    logic tie;
    logic alpha_drv;
    int   n_assert;
    int   n_fail;
    logic ok;

    dogx_digital_converter_v2_if bus ();

    dogx_digital_converter_v2 #(
        .HDR_SHIFT  (2),
        .DC_SHIFT   (10),
        .FADE_STEPS (4)
    ) dut (
        .CLK_24M (clk),
        .reset   (rst_n),
        .io_bus  (bus)
    );

    assign bus.alpha_in = tie ? bus.alpha_out : alpha_drv;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [15:0] obs,
                         input logic signed [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Advance counters by the given increments, then sample just after the edge.
    task automatic step(input int hp, input int hn, input int dp, input int dn);
        bus.counter_HSNR_p = bus.counter_HSNR_p + 9'(hp);
        bus.counter_HSNR_n = bus.counter_HSNR_n + 9'(hn);
        bus.counter_HDR_p  = bus.counter_HDR_p + 9'(dp);
        bus.counter_HDR_n  = bus.counter_HDR_n + 9'(dn);
        @(posedge clk);
        #1;
    endtask

    int prog_exp [6] = '{16, 20, 24, 28, 32, 32};

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        tie      = 1'b0;
        alpha_drv = 1'b0;
        bus.counter_HSNR_p = '0;
        bus.counter_HSNR_n = '0;
        bus.counter_HDR_p  = '0;
        bus.counter_HDR_n  = '0;
        bus.alpha_th_high  = 9'd511;
        bus.alpha_th_low   = 9'd0;
        bus.alpha_timeout_mask    = 5'd0;
        bus.use_progressive_alpha = 1'b0;
        bus.use_dc_filter         = 1'b0;

        // Reset held with counters running.
        repeat (3) step(270, 254, 264, 260);
        check("reset_out", 16'(bus.converter_output), 16'sd0);
        check("reset_alpha", 16'(bus.alpha_out), 16'sd0);

        rst_n = 1'b1;
        step(270, 254, 264, 260);
        check("first_sample", 16'(bus.converter_output), 16'sd0);

        // Equal p/n rates with wrap.
        step(262, 262, 262, 262);
        check("equal_rates_out", 16'(bus.converter_output), 16'sd0);
        step(262, 262, 262, 262);
        check("equal_rates_alpha", 16'(bus.alpha_out), 16'sd0);

        // hsnr=16, hdr=4, alpha_in=0.
        step(270, 254, 264, 260);
        check("hsnr_sel", 16'(bus.converter_output), 16'sd16);
        check("hsnr_alpha", 16'(bus.alpha_out), 16'sd0);

        // alpha_in tied to alpha_out, th_high=3.
        bus.alpha_th_high = 9'd3;
        tie = 1'b1;
        step(270, 254, 264, 260);
        check("tie_alpha_rise", 16'(bus.alpha_out), 16'sd1);
        check("tie_first_out", 16'(bus.converter_output), 16'sd16);
        step(270, 254, 264, 260);
        check("tie_hdr_out", 16'(bus.converter_output), 16'sd16);
        step(270, 254, 266, 260);
        check("tie_hdr6_out", 16'(bus.converter_output), 16'sd24);

        // Hysteresis: first drop back to LOW via mask=1.
        tie = 1'b0;
        alpha_drv = 1'b0;
        bus.alpha_th_high = 9'd10;
        bus.alpha_th_low  = 9'd7;
        bus.alpha_timeout_mask = 5'b00001;
        step(262, 262, 262, 262);
        check("mask1_fall", 16'(bus.alpha_out), 16'sd0);

        bus.alpha_timeout_mask = 5'b00100;
        step(262, 262, 272, 260);
        check("hyst_rise", 16'(bus.alpha_out), 16'sd1);
        repeat (3) step(262, 262, 265, 260);
        check("hyst_hold3", 16'(bus.alpha_out), 16'sd1);
        step(262, 262, 265, 260);
        check("hyst_fall4", 16'(bus.alpha_out), 16'sd0);

        step(262, 262, 260, 272);
        check("neg_hdr_rise", 16'(bus.alpha_out), 16'sd1);
        repeat (6) step(262, 262, 268, 260);
        check("mid_band_hold", 16'(bus.alpha_out), 16'sd1);
        repeat (3) step(262, 262, 265, 260);
        check("timeout_hold3", 16'(bus.alpha_out), 16'sd1);
        step(262, 262, 265, 260);
        check("timeout_fall4", 16'(bus.alpha_out), 16'sd0);

        // Progressive crossfade: hsnr=16, hdr=8.
        bus.alpha_th_high = 9'd511;
        bus.alpha_timeout_mask = 5'd0;
        bus.use_progressive_alpha = 1'b1;
        step(270, 254, 268, 260);
        check("prog_idle", 16'(bus.converter_output), 16'sd16);
        alpha_drv = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step(270, 254, 268, 260);
            check($sformatf("prog_up%0d", i), 16'(bus.converter_output), 16'(prog_exp[i]));
        end
        alpha_drv = 1'b0;
        step(270, 254, 268, 260);
        check("prog_down0", 16'(bus.converter_output), 16'sd32);
        step(270, 254, 268, 260);
        check("prog_down1", 16'(bus.converter_output), 16'sd28);
        bus.use_progressive_alpha = 1'b0;
        step(270, 254, 268, 260);
        check("prog_off_hard", 16'(bus.converter_output), 16'sd16);

        // DC filter with constant sel=100.
        bus.use_dc_filter = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step(312, 212, 262, 262);
            if (k == 1)  check("dc_first", 16'(bus.converter_output), 16'sd100);
            if (k == 11) check("dc_k11", 16'(bus.converter_output), 16'sd100);
            if (k == 12) check("dc_k12", 16'(bus.converter_output), 16'sd99);
        end
        for (int k = 0; k < 4000; k++) step(312, 212, 262, 262);
        ok = (bus.converter_output >= 11'sd0) && (bus.converter_output <= 11'sd5);
        check("dc_decayed", 16'(ok), 16'sd1);
        bus.use_dc_filter = 1'b0;
        step(312, 212, 262, 262);
        check("dc_off", 16'(bus.converter_output), 16'sd100);
        bus.use_dc_filter = 1'b1;
        step(312, 212, 262, 262);
        check("dc_reenable", 16'(bus.converter_output), 16'sd100);

        // Saturation.
        bus.use_dc_filter = 1'b0;
        bus.alpha_th_high = 9'd100;
        alpha_drv = 1'b1;
        step(262, 262, 400, 100);
        check("sat_pos", 16'(bus.converter_output), 16'sd1023);
        check("sat_alpha", 16'(bus.alpha_out), 16'sd1);
        step(262, 262, 100, 400);
        check("sat_neg", 16'(bus.converter_output), -16'sd1024);
        alpha_drv = 1'b0;
        step(254, 270, 262, 262);
        check("hsnr_negative", 16'(bus.converter_output), -16'sd16);

        // Asynchronous reset between edges.
        #3;
        rst_n = 1'b0;
        #1;
        check("async_reset_out", 16'(bus.converter_output), 16'sd0);
        check("async_reset_alpha", 16'(bus.alpha_out), 16'sd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
